// File: rtl/channel_normalizer.sv
// Multi-channel pixel normaliser: out = sat(round(((pixel - mean[ch]) * scale[ch]) >> FRAC)).
// Three-stage valid/ready pipeline with double-buffered (shadow/active) per-channel coefficients.
module channel_normalizer #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 8,
    parameter int NUM_CH = 3,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic [IN_W-1:0]          in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_pixel,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_sat,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [IN_W-1:0]          cfg_mean,
    input  logic signed [COEF_W-1:0] cfg_scale,
    input  logic                     cfg_commit
);

    localparam int PROD_W = IN_W + 1 + COEF_W;
    // Wide enough to hold the rounded product and both saturation limits without overflow.
    localparam int CMP_W  = (PROD_W + 1 > OUT_W + 1) ? PROD_W + 1 : OUT_W + 1;

    localparam logic signed [COEF_W-1:0] UNITY   = COEF_W'(1) << FRAC;
    localparam logic signed [CMP_W-1:0]  ROUND   = CMP_W'(1) << (FRAC - 1);
    localparam logic signed [CMP_W-1:0]  MAX_V   = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0]  MIN_V   = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [CH_W-1:0]          LAST_CH = CH_W'(NUM_CH - 1);

    logic                     en;
    logic                     accept;
    logic [CH_W-1:0]          ch_cnt_reg;
    logic [CH_W-1:0]          ch_sel;
    logic [CH_W-1:0]          ch_next;
    logic signed [IN_W:0]     diff_next;

    logic [IN_W-1:0]          act_mean  [NUM_CH];
    logic signed [COEF_W-1:0] act_scale [NUM_CH];

    logic                     s1_valid_reg;
    logic signed [IN_W:0]     s1_diff_reg;
    logic signed [COEF_W-1:0] s1_scale_reg;
    logic [CH_W-1:0]          s1_ch_reg;

    logic                     s2_valid_reg;
    logic signed [PROD_W-1:0] s2_prod_reg;
    logic [CH_W-1:0]          s2_ch_reg;

    logic signed [CMP_W-1:0]  round_sum;
    logic signed [CMP_W-1:0]  round_res;
    logic signed [OUT_W-1:0]  pixel_next;
    logic                     sat_next;

    logic                     out_valid_reg;
    logic signed [OUT_W-1:0]  out_pixel_reg;
    logic [CH_W-1:0]          out_ch_reg;
    logic                     out_sat_reg;

    // The whole pipeline moves in lock step: it stalls only when the output is held.
    assign en        = out_ready | ~out_valid_reg;
    assign in_ready  = en;
    assign accept    = in_valid & en;

    assign out_valid = out_valid_reg;
    assign out_pixel = out_pixel_reg;
    assign out_ch    = out_ch_reg;
    assign out_sat   = out_sat_reg;

    // Per-channel coefficient storage: shadow is written by software, active feeds the datapath.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_coef
            logic [IN_W-1:0]          sh_mean_reg;
            logic signed [COEF_W-1:0] sh_scale_reg;
            logic [IN_W-1:0]          act_mean_reg;
            logic signed [COEF_W-1:0] act_scale_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sh_mean_reg   <= '0;
                    sh_scale_reg  <= UNITY;
                    act_mean_reg  <= '0;
                    act_scale_reg <= UNITY;
                end else begin
                    if (cfg_commit) begin
                        act_mean_reg  <= sh_mean_reg;
                        act_scale_reg <= sh_scale_reg;
                    end
                    if (cfg_we && (cfg_ch == CH_W'(gi))) begin
                        sh_mean_reg  <= cfg_mean;
                        sh_scale_reg <= cfg_scale;
                    end
                end
            end

            assign act_mean[gi]  = act_mean_reg;
            assign act_scale[gi] = act_scale_reg;
        end
    endgenerate

    assign ch_sel    = in_sof ? '0 : ch_cnt_reg;
    assign ch_next   = (ch_sel == LAST_CH) ? '0 : ch_sel + 1'b1;
    assign diff_next = {1'b0, in_pixel} - {1'b0, act_mean[ch_sel]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_reg <= '0;
        end else if (accept) begin
            ch_cnt_reg <= ch_next;
        end
    end

    // Stage 1: subtract the mean and bind the coefficients in force at accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_diff_reg  <= '0;
            s1_scale_reg <= '0;
            s1_ch_reg    <= '0;
        end else if (en) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_diff_reg  <= diff_next;
                s1_scale_reg <= act_scale[ch_sel];
                s1_ch_reg    <= ch_sel;
            end
        end
    end

    // Stage 2: full-precision signed product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_prod_reg  <= '0;
            s2_ch_reg    <= '0;
        end else if (en) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_prod_reg <= s1_diff_reg * s1_scale_reg;
                s2_ch_reg   <= s1_ch_reg;
            end
        end
    end

    // Stage 3: round half toward +inf, then clamp to the signed output range.
    assign round_sum = CMP_W'(s2_prod_reg) + ROUND;
    assign round_res = round_sum >>> FRAC;

    always_comb begin
        pixel_next = round_res[OUT_W-1:0];
        sat_next   = 1'b0;
        if (round_res > MAX_V) begin
            pixel_next = MAX_V[OUT_W-1:0];
            sat_next   = 1'b1;
        end else if (round_res < MIN_V) begin
            pixel_next = MIN_V[OUT_W-1:0];
            sat_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_pixel_reg <= '0;
            out_ch_reg    <= '0;
            out_sat_reg   <= 1'b0;
        end else if (en) begin
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_pixel_reg <= pixel_next;
                out_ch_reg    <= s2_ch_reg;
                out_sat_reg   <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_channel_normalizer.sv
// Bench for channel_normalizer: two instances (16-bit and 12-bit outputs) share one stimulus
// stream and are compared every output transfer against a queue-based arithmetic model.
module tb_channel_normalizer;

    localparam int IN_W   = 8;
    localparam int COEF_W = 16;
    localparam int FRAC   = 8;
    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic                     in_valid = 1'b0;
    logic                     in_sof = 1'b0;
    logic [IN_W-1:0]          in_pixel = '0;
    logic                     out_ready = 1'b1;
    logic                     cfg_we = 1'b0;
    logic [CH_W-1:0]          cfg_ch = '0;
    logic [IN_W-1:0]          cfg_mean = '0;
    logic signed [COEF_W-1:0] cfg_scale = '0;
    logic                     cfg_commit = 1'b0;

    logic               in_ready_a, out_valid_a, out_sat_a;
    logic signed [15:0] out_pixel_a;
    logic [CH_W-1:0]    out_ch_a;
    logic               in_ready_b, out_valid_b, out_sat_b;
    logic signed [11:0] out_pixel_b;
    logic [CH_W-1:0]    out_ch_b;

    channel_normalizer #(.IN_W(IN_W), .OUT_W(16), .COEF_W(COEF_W), .FRAC(FRAC), .NUM_CH(NUM_CH)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_sof(in_sof),
        .in_pixel(in_pixel), .out_valid(out_valid_a), .out_ready(out_ready), .out_pixel(out_pixel_a),
        .out_ch(out_ch_a), .out_sat(out_sat_a), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mean(cfg_mean),
        .cfg_scale(cfg_scale), .cfg_commit(cfg_commit));

    channel_normalizer #(.IN_W(IN_W), .OUT_W(12), .COEF_W(COEF_W), .FRAC(FRAC), .NUM_CH(NUM_CH)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_sof(in_sof),
        .in_pixel(in_pixel), .out_valid(out_valid_b), .out_ready(out_ready), .out_pixel(out_pixel_b),
        .out_ch(out_ch_b), .out_sat(out_sat_b), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mean(cfg_mean),
        .cfg_scale(cfg_scale), .cfg_commit(cfg_commit));

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int pa; int sa; int pb; int sb; int ch;
    } exp_t;

    exp_t exp_q[$];
    int   sh_mean[NUM_CH], sh_scale[NUM_CH], act_mean[NUM_CH], act_scale[NUM_CH];
    int   m_cnt;
    int   acc_cnt = 0;
    int   out_cnt = 0;
    int   obs_pa[$], obs_sa[$], obs_pb[$], obs_sb[$], obs_ch[$];

    function automatic int model_r(input int pix, input int mean, input int scale);
        return ((pix - mean) * scale + (1 << (FRAC - 1))) >>> FRAC;
    endfunction

    function automatic int clip(input int r, input int w);
        int mx = (1 << (w - 1)) - 1;
        int mn = -(1 << (w - 1));
        if (r > mx) return mx;
        if (r < mn) return mn;
        return r;
    endfunction

    function automatic int is_sat(input int r, input int w);
        return ((r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)))) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            sh_mean[c] = 0; sh_scale[c] = 1 << FRAC;
            act_mean[c] = 0; act_scale[c] = 1 << FRAC;
        end
        m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic obs_clear();
        obs_pa.delete(); obs_sa.delete(); obs_pb.delete(); obs_sb.delete(); obs_ch.delete();
    endtask

    // Compare process: samples on the falling edge what the next rising edge will act on.
    initial begin
        exp_t e;
        bit   stall_prev = 1'b0;
        int   held_pa = 0, held_sa = 0, held_pb = 0, held_ch = 0;
        int   ch, r;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                stall_prev = 1'b0;
                chk("rst_out_valid_a", int'(out_valid_a), 0);
                chk("rst_out_valid_b", int'(out_valid_b), 0);
            end else begin
                if (stall_prev) begin
                    chk("stall_pixel_a", int'(out_pixel_a), held_pa);
                    chk("stall_sat_a", int'(out_sat_a), held_sa);
                    chk("stall_pixel_b", int'(out_pixel_b), held_pb);
                    chk("stall_ch", int'(out_ch_a), held_ch);
                end
                stall_prev = out_valid_a && !out_ready;
                held_pa = out_pixel_a; held_sa = out_sat_a; held_pb = out_pixel_b; held_ch = out_ch_a;

                if (out_valid_a && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pixel_a", int'(out_pixel_a), e.pa);
                        chk("out_sat_a", int'(out_sat_a), e.sa);
                        chk("out_ch_a", int'(out_ch_a), e.ch);
                        chk("out_valid_b", int'(out_valid_b), 1);
                        chk("out_pixel_b", int'(out_pixel_b), e.pb);
                        chk("out_sat_b", int'(out_sat_b), e.sb);
                        chk("out_ch_b", int'(out_ch_b), e.ch);
                        obs_pa.push_back(out_pixel_a); obs_sa.push_back(out_sat_a);
                        obs_pb.push_back(out_pixel_b); obs_sb.push_back(out_sat_b);
                        obs_ch.push_back(out_ch_a);
                        out_cnt++;
                    end
                end

                if (in_valid && in_ready_a) begin
                    ch = in_sof ? 0 : m_cnt;
                    r = model_r(in_pixel, act_mean[ch], act_scale[ch]);
                    e.pa = clip(r, 16); e.sa = is_sat(r, 16);
                    e.pb = clip(r, 12); e.sb = is_sat(r, 12);
                    e.ch = ch;
                    exp_q.push_back(e);
                    m_cnt = (ch + 1) % NUM_CH;
                    acc_cnt++;
                end

                if (cfg_commit) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        act_mean[c] = sh_mean[c];
                        act_scale[c] = sh_scale[c];
                    end
                end
                if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
                    sh_mean[cfg_ch] = cfg_mean;
                    sh_scale[cfg_ch] = cfg_scale;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input int pix, input bit sof);
        in_valid = 1'b1; in_pixel = IN_W'(pix); in_sof = sof;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready_a) begin
                @(posedge clk); #1;
                in_valid = 1'b0; in_sof = 1'b0;
                $display("send pixel=%0d sof=%0d", pix, sof);
                return;
            end
        end
        chk("send_timeout", 1, 0);
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int mean, input int scale);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_mean = IN_W'(mean); cfg_scale = COEF_W'(scale);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        $display("cfg ch=%0d mean=%0d scale=%0d", ch, mean, scale);
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        $display("commit");
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(posedge clk);
        chk("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        int lat;
        int oc, a0;
        int exp_ch[7] = '{0, 1, 2, 0, 0, 1, 2};
        int exp6_p[6] = '{10, 50, 20, 30, 0, 40};
        int exp6_c[6] = '{0, 1, 2, 0, 1, 2};

        #3 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_out_valid", int'(out_valid_a), 0);
        chk("reset_out_pixel", int'(out_pixel_a), 0);
        chk("reset_out_ch", int'(out_ch_a), 0);
        chk("reset_out_sat", int'(out_sat_a), 0);
        chk("reset_in_ready", int'(in_ready_a), 1);
        chk("reset_out_pixel_b", int'(out_pixel_b), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // model pins
        chk("pin_254", model_r(255, 128, 512), 254);
        chk("pin_m256", model_r(0, 128, 512), -256);
        chk("pin_sat_hi", clip(model_r(255, 0, 32767), 12), 2047);
        chk("pin_sat_lo", clip(model_r(0, 255, 32767), 12), -2048);

        // identity coefficients and latency
        send(200, 1'b1);
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid_a) break;
        end
        chk("latency", lat, 3);
        chk("t1_pixel", int'(out_pixel_a), 200);
        chk("t1_ch", int'(out_ch_a), 0);
        chk("t1_sat", int'(out_sat_a), 0);
        drain();

        // mean/scale on channel 0
        cfg_write(0, 128, 512);
        commit();
        obs_clear();
        send(255, 1'b1); send(0, 1'b1); send(128, 1'b1);
        drain();
        chk("t2_count", obs_pa.size(), 3);
        chk("t2_p0", obs_pa[0], 254);
        chk("t2_p1", obs_pa[1], -256);
        chk("t2_p2", obs_pa[2], 0);

        // saturation on the 12-bit instance
        cfg_write(0, 0, 32767);
        commit();
        obs_clear();
        send(255, 1'b1);
        drain();
        chk("t3_hi_b", obs_pb[0], 2047);
        chk("t3_hi_sat_b", obs_sb[0], 1);
        chk("t3_hi_a", obs_pa[0], 32639);
        chk("t3_hi_sat_a", obs_sa[0], 0);
        cfg_write(0, 255, 32767);
        commit();
        obs_clear();
        send(0, 1'b1);
        drain();
        chk("t3_lo_b", obs_pb[0], -2048);
        chk("t3_lo_sat_b", obs_sb[0], 1);
        chk("t3_lo_a", obs_pa[0], -32639);
        cfg_write(0, 0, 256);
        commit();

        // backpressure
        out_ready = 1'b0;
        obs_clear();
        a0 = acc_cnt;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(i, i == 1);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("t4_in_ready_low", int'(in_ready_a), 0);
                chk("t4_held", acc_cnt - a0, 3);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t4_count", obs_pa.size(), 6);
        for (int i = 0; i < 6; i++) chk("t4_order", obs_pa[i], i + 1);

        // channel sequence with a mid-stream start-of-frame; out-of-range cfg_ch ignored
        cfg_write(3, 99, 0);
        commit();
        obs_clear();
        for (int i = 0; i < 7; i++) send(10 + i, (i == 0) || (i == 4));
        drain();
        chk("t5_count", obs_ch.size(), 7);
        for (int i = 0; i < 7; i++) chk("t5_ch", obs_ch[i], exp_ch[i]);
        for (int i = 0; i < 7; i++) chk("t5_pix", obs_pa[i], 10 + i);

        // commit coincident with accept, and write coincident with commit
        cfg_write(1, 0, 0);
        obs_clear();
        in_valid = 1'b1; in_sof = 1'b1; in_pixel = 8'd10;
        @(posedge clk); #1;
        in_sof = 1'b0; in_pixel = 8'd50;
        cfg_commit = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mean = 8'd0; cfg_scale = 16'sd512;
        @(posedge clk); #1;
        cfg_commit = 1'b0; cfg_we = 1'b0; in_pixel = 8'd20;
        @(posedge clk); #1;
        in_pixel = 8'd30;
        @(posedge clk); #1;
        in_pixel = 8'd50;
        @(posedge clk); #1;
        in_valid = 1'b0;
        commit();
        send(20, 1'b0);
        drain();
        chk("t6_count", obs_pa.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("t6_pix", obs_pa[i], exp6_p[i]);
            chk("t6_ch", obs_ch[i], exp6_c[i]);
        end

        // reset with pixels in flight
        send(5, 1'b1);
        send(6, 1'b0);
        @(posedge clk); #1;
        chk("t7_pre_valid", int'(out_valid_a), 1);
        rst_n = 1'b0;
        #1;
        chk("t7_valid_a", int'(out_valid_a), 0);
        chk("t7_valid_b", int'(out_valid_b), 0);
        chk("t7_pixel", int'(out_pixel_a), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        oc = out_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("t7_no_output", out_cnt - oc, 0);
        chk("t7_idle_valid", int'(out_valid_a), 0);
        obs_clear();
        send(77, 1'b1);
        send(33, 1'b0);
        drain();
        chk("t7_count", obs_pa.size(), 2);
        chk("t7_ch0_identity", obs_pa[0], 77);
        chk("t7_ch1_identity", obs_pa[1], 33);
        chk("t7_ch1", obs_ch[1], 1);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
